// File: rtl/sram_req_ctrl.sv
// Request-side sequencer for a single-port SRAM: single-word writes and burst
// reads over valid/ready, read data returned as a registered stream with a last flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a request, SRAM idle, mem_addr holds last value
// S_WRITE | one cycle with mem_en high, SRAM writes at the next edge
// S_READ  | one address per cycle, base+k wrapping mod M, for k = 0..len
// S_DRAIN | two cycles letting the last beats leave the read pipeline
module sram_req_ctrl #(
    parameter int N = 4,
    parameter int M = 16,
    localparam int A = $clog2(M)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [A-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    input  logic [A-1:0] req_len,
    output logic [A-1:0] mem_addr,
    output logic [N-1:0] mem_din,
    output logic         mem_en,
    input  logic [N-1:0] mem_dout,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_data,
    output logic         rsp_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t       state_q;
    logic [A-1:0] cnt_q;
    logic [A-1:0] len_q;
    logic [A-1:0] mem_addr_q;
    logic [N-1:0] mem_din_q;
    logic         mem_en_q;
    logic         req_ready_q;
    logic         busy_q;
    logic         pipe_vld_q;
    logic         pipe_last_q;
    logic         rsp_valid_q;
    logic         rsp_last_q;
    logic [N-1:0] rsp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_en_q    <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_last_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            // Stage 0 marks the address cycle just ended; the SRAM has its dout
            // registered by then, so stage 1 captures it into the response.
            pipe_vld_q  <= 1'b0;
            pipe_last_q <= 1'b0;
            rsp_valid_q <= pipe_vld_q;
            rsp_last_q  <= pipe_last_q;
            if (pipe_vld_q) begin
                rsp_data_q <= mem_dout;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        mem_addr_q  <= req_addr;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        if (req_write) begin
                            state_q   <= S_WRITE;
                            mem_din_q <= req_wdata;
                            mem_en_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            len_q   <= req_len;
                        end
                    end
                end
                S_WRITE: begin
                    mem_en_q    <= 1'b0;
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                S_READ: begin
                    pipe_vld_q  <= 1'b1;
                    pipe_last_q <= (cnt_q == len_q);
                    if (cnt_q == len_q) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q      <= cnt_q + 1'b1;
                        mem_addr_q <= mem_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == A'(1)) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    mem_en_q    <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_en    = mem_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: SRAM model, per-cycle scheduled reference model,
// directed request table, hand sequences and randomized traffic.
module tb_sram_req_ctrl;
    localparam int N = 4;
    localparam int M = 16;
    localparam int A = 4;
    localparam int R = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [A-1:0] req_addr = '0;
    logic [N-1:0] req_wdata = '0;
    logic [A-1:0] req_len = '0;
    logic [A-1:0] mem_addr;
    logic [N-1:0] mem_din;
    logic         mem_en;
    logic [N-1:0] mem_dout;
    logic         rsp_valid;
    logic [N-1:0] rsp_data;
    logic         rsp_last;
    logic         busy;

    always #5 clk = ~clk;

    sram_req_ctrl #(.N(N), .M(M)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_dout(mem_dout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
    );

    // Single-port SRAM: write when en, registered read otherwise
    logic [N-1:0] sram [M];
    always @(posedge clk) begin
        if (mem_en) sram[mem_addr] <= mem_din;
        else        mem_dout <= sram[mem_addr];
    end

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: expectations scheduled per absolute cycle number
    logic         s_en   [R];
    logic         s_av   [R];
    logic [A-1:0] s_addr [R];
    logic [N-1:0] s_din  [R];
    logic         s_rv   [R];
    logic         s_dv   [R];
    logic [N-1:0] s_rd   [R];
    logic         s_rl   [R];
    logic         s_rst  [R];
    logic [N-1:0] shadow [M];
    logic         known  [M];
    int           free_at = 0;
    logic         checking = 1'b0;
    int           acc_cyc[$];
    logic [N-1:0] obs_d[$];
    logic         obs_l[$];
    int           beat_cnt = 0;

    initial begin
        for (int k = 0; k < R; k++) begin
            s_en[k] = 0; s_av[k] = 0; s_addr[k] = '0; s_din[k] = '0; s_rv[k] = 0;
            s_dv[k] = 0; s_rd[k] = '0; s_rl[k] = 0; s_rst[k] = 0;
        end
        for (int k = 0; k < M; k++) begin
            shadow[k] = '0; known[k] = 0;
        end
    end

    always @(negedge clk) begin
        int n, i, a, j;
        logic er;
        n = cyc;
        i = n % R;
        if (checking) begin
            er = (n >= free_at);
            chk("req_ready", req_ready, er);
            chk("busy", busy, !er);
            chk("mem_en", mem_en, s_en[i]);
            if (s_av[i]) chk("mem_addr", mem_addr, s_addr[i]);
            if (s_en[i]) chk("mem_din", mem_din, s_din[i]);
            chk("rsp_valid", rsp_valid, s_rv[i]);
            if (s_rv[i]) begin
                chk("rsp_last", rsp_last, s_rl[i]);
                if (s_dv[i]) chk("rsp_data", rsp_data, s_rd[i]);
            end
            if (s_rst[i]) begin
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_din", mem_din, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_rsp_last", rsp_last, 0);
            end
        end
        if (rsp_valid === 1'b1) begin
            obs_d.push_back(rsp_data);
            obs_l.push_back(rsp_last);
            beat_cnt++;
        end
        s_en[i] = 0; s_av[i] = 0; s_rv[i] = 0; s_dv[i] = 0; s_rl[i] = 0; s_rst[i] = 0;

        if (reset) begin
            for (int k = 0; k < R; k++) begin
                s_en[k] = 0; s_av[k] = 0; s_rv[k] = 0; s_dv[k] = 0; s_rl[k] = 0; s_rst[k] = 0;
            end
            free_at = n + 1;
            s_rst[(n + 1) % R] = 1;
            checking = 1'b1;
        end else if (checking && n >= free_at && req_valid) begin
            acc_cyc.push_back(n);
            if (req_write) begin
                j = (n + 1) % R;
                s_en[j] = 1; s_av[j] = 1; s_addr[j] = req_addr; s_din[j] = req_wdata;
                shadow[req_addr] = req_wdata;
                known[req_addr] = 1;
                free_at = n + 2;
            end else begin
                for (int k = 0; k <= int'(req_len); k++) begin
                    a = (int'(req_addr) + k) % M;
                    j = (n + 1 + k) % R;
                    s_av[j] = 1; s_addr[j] = A'(a);
                    j = (n + 3 + k) % R;
                    s_rv[j] = 1; s_rd[j] = shadow[a]; s_dv[j] = known[a];
                    s_rl[j] = (k == int'(req_len));
                end
                free_at = n + int'(req_len) + 4;
            end
        end
    end

    // Present a request and hold it until the controller takes it
    task automatic send(input bit w, input int addr, input int data, input int len, input bit hold);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = A'(addr);
        req_wdata = N'(data);
        req_len   = A'(len);
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (req_ready) break;
            if (t > 200) begin
                tests++; failed++;
                $display("FAIL accept_timeout: ready stayed %0b, expected 1 within 200 cycles", req_ready);
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (req_ready && !busy) break;
            if (t > 200) begin
                tests++; failed++;
                $display("FAIL idle_timeout: busy stayed %0b, expected 0 within 200 cycles", busy);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit w;
        int addr;
        int data;
        int len;
        int exp_beats;
        int exp_first;
        int exp_lastd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        tests++; failed++;
        $display("FAIL watchdog: simulation time exhausted");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        int nlast, b0;
        vecs.push_back('{1, 3, 'hA, 0, 0, 0, 0});
        vecs.push_back('{0, 3, 0, 0, 1, 'hA, 'hA});
        for (int k = 0; k < M; k++) vecs.push_back('{1, k, k ^ 5, 0, 0, 0, 0});
        vecs.push_back('{0, 4, 0, 3, 4, 'h1, 'h2});
        vecs.push_back('{0, 14, 0, 3, 4, 'hB, 'h4});
        vecs.push_back('{0, 0, 0, 15, 16, 'h5, 'hA});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < vecs.size(); t++) begin
            obs_d.delete(); obs_l.delete();
            send(vecs[t].w, vecs[t].addr, vecs[t].data, vecs[t].len, 0);
            wait_idle();
            chk($sformatf("vec%0d_beats", t), obs_d.size(), vecs[t].exp_beats);
            if (vecs[t].exp_beats > 0 && obs_d.size() > 0) begin
                nlast = 0;
                foreach (obs_l[k]) if (obs_l[k]) nlast++;
                chk($sformatf("vec%0d_first", t), obs_d[0], vecs[t].exp_first);
                chk($sformatf("vec%0d_lastdata", t), obs_d[obs_d.size() - 1], vecs[t].exp_lastd);
                chk($sformatf("vec%0d_lastflag", t), obs_l[obs_l.size() - 1], 1);
                chk($sformatf("vec%0d_nlast", t), nlast, 1);
            end
        end

        // Back-to-back writes with req_valid held
        acc_cyc.delete();
        send(1, 7, 'hC, 0, 1);
        send(1, 8, 'hD, 0, 1);
        send(1, 9, 'hE, 0, 0);
        chk("b2b_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 2);
            chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 2);
        end
        wait_idle();
        obs_d.delete(); obs_l.delete();
        send(0, 7, 0, 2, 0);
        wait_idle();
        chk("b2b_beats", obs_d.size(), 3);
        if (obs_d.size() == 3) begin
            chk("b2b_rd7", obs_d[0], 'hC);
            chk("b2b_rd8", obs_d[1], 'hD);
            chk("b2b_rd9", obs_d[2], 'hE);
        end

        // Reset in the middle of a full-depth burst
        b0 = beat_cnt;
        send(0, 0, 0, 15, 0);
        for (int t = 0; beat_cnt - b0 < 5; t++) begin
            @(negedge clk);
            if (t > 100) begin
                tests++; failed++;
                $display("FAIL midburst_timeout: beats %0d, expected 5", beat_cnt - b0);
                break;
            end
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_mem_en", mem_en, 0);
        chk("post_rst_req_ready", req_ready, 1);
        b0 = beat_cnt;
        repeat (20) @(negedge clk);
        chk("post_rst_no_beats", beat_cnt - b0, 0);
        @(posedge clk); #1;
        send(1, 2, 'h9, 0, 0);
        wait_idle();
        obs_d.delete(); obs_l.delete();
        send(0, 2, 0, 0, 0);
        wait_idle();
        chk("post_rst_beats", obs_d.size(), 1);
        if (obs_d.size() == 1) chk("post_rst_rd2", obs_d[0], 'h9);

        // Randomized traffic, checked cycle by cycle by the model
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1)
                send(1, $urandom_range(0, M - 1), $urandom_range(0, (1 << N) - 1), $urandom_range(0, M - 1), $urandom_range(0, 1));
            else
                send(0, $urandom_range(0, M - 1), $urandom_range(0, (1 << N) - 1), $urandom_range(0, M - 1), $urandom_range(0, 1));
        end
        req_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
